// File: rtl/store_pkg.sv
// Shared types and encodings for the buffered store unit: funct3 codes, access
// sizes, fault causes and the queued store entry.
package store_pkg;

    localparam int unsigned XLEN_MAX = 64;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;
    localparam logic [2:0] F3_SD = 3'b011;

    typedef enum logic [2:0] {
        SZ_NONE = 3'b000,
        SZ_B    = 3'b001,
        SZ_H    = 3'b010,
        SZ_W    = 3'b011,
        SZ_D    = 3'b100
    } size_e;

    typedef enum logic [1:0] {
        EXC_NONE     = 2'b00,
        EXC_MISALIGN = 2'b01,
        EXC_ILLEGAL  = 2'b10
    } exc_cause_e;

    // Fields are sized for the widest datapath; narrower builds zero-extend.
    typedef struct packed {
        logic [XLEN_MAX-1:0]   addr;
        logic [XLEN_MAX-1:0]   wdata;
        logic [XLEN_MAX/8-1:0] wstrb;
        size_e                 size;
    } store_entry_t;

    function automatic logic [7:0] size_mask(input size_e sz);
        logic [7:0] m;
        case (sz)
            SZ_B:    m = 8'h01;
            SZ_H:    m = 8'h03;
            SZ_W:    m = 8'h0F;
            SZ_D:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_align.sv
// Combinational store decode: effective address, access size, lane-aligned data
// and byte strobes, plus funct3 legality and alignment fault detection.
module store_align
    import store_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] src1_i,
    input  logic [XLEN-1:0] src2_i,
    input  logic [2:0]      funct3_i,
    input  logic [11:0]     imm12_i,
    output store_entry_t    entry_o,
    output logic            fault_o,
    output exc_cause_e      cause_o,
    output logic [XLEN-1:0] addr_o
);

    localparam int unsigned OFF_W = (XLEN == 64) ? 3 : 2;

    logic [XLEN-1:0]  addr;
    logic [OFF_W-1:0] off;
    size_e            size;
    logic             illegal;
    logic             misalign;
    logic [7:0]       mask8;
    logic [7:0]       strb;
    logic [XLEN-1:0]  data_mask;
    logic [XLEN-1:0]  wdata;

    assign addr = src1_i + {{(XLEN-12){imm12_i[11]}}, imm12_i};
    assign off  = addr[OFF_W-1:0];

    always_comb begin
        size    = SZ_NONE;
        illegal = 1'b0;
        case (funct3_i)
            F3_SB: size = SZ_B;
            F3_SH: size = SZ_H;
            F3_SW: size = SZ_W;
            F3_SD: begin
                if (XLEN == 64) size = SZ_D;
                else            illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        misalign = 1'b0;
        case (size)
            SZ_H:    misalign = addr[0];
            SZ_W:    misalign = (addr[1:0] != 2'b00);
            SZ_D:    misalign = (addr[2:0] != 3'b000);
            default: misalign = 1'b0;
        endcase
    end

    assign mask8 = size_mask(size);
    assign strb  = mask8 << off;

    always_comb begin
        data_mask = '0;
        for (int unsigned b = 0; b < XLEN/8; b++) begin
            data_mask[b*8 +: 8] = {8{mask8[b]}};
        end
    end

    assign wdata = (src2_i & data_mask) << {off, 3'b000};

    always_comb begin
        entry_o       = '0;
        entry_o.addr  = XLEN_MAX'(addr);
        entry_o.wdata = XLEN_MAX'(wdata);
        entry_o.wstrb = strb;
        entry_o.size  = size;
    end

    assign fault_o = illegal | misalign;
    assign cause_o = illegal  ? EXC_ILLEGAL  :
                     misalign ? EXC_MISALIGN : EXC_NONE;
    assign addr_o  = addr;

endmodule

// File: rtl/store_queue.sv
// Buffered store unit: decodes stores, reports faults as a one-cycle pulse and
// drains legal stores in order from a DEPTH-entry FIFO to the memory port.
module store_queue
    import store_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = $clog2(DEPTH+1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   src1_data,
    input  logic [XLEN-1:0]   src2_data,
    input  logic [2:0]        funct3,
    input  logic [11:0]       imm12,
    output logic              exc_valid,
    output logic [1:0]        exc_cause,
    output logic [XLEN-1:0]   exc_addr,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    output logic [2:0]        mem_size,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    store_entry_t    new_entry;
    logic            fault;
    exc_cause_e      cause;
    logic [XLEN-1:0] fault_addr;

    store_align #(.XLEN(XLEN)) u_align (
        .src1_i   (src1_data),
        .src2_i   (src2_data),
        .funct3_i (funct3),
        .imm12_i  (imm12),
        .entry_o  (new_entry),
        .fault_o  (fault),
        .cause_o  (cause),
        .addr_o   (fault_addr)
    );

    store_entry_t     fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             exc_valid_q, exc_valid_d;
    exc_cause_e       exc_cause_q, exc_cause_d;
    logic [XLEN-1:0]  exc_addr_q, exc_addr_d;

    logic         accept;
    logic         enq;
    logic         deq;
    store_entry_t head;

    // in_ready depends only on full, so a same-cycle dequeue never frees a slot.
    assign in_ready = (count_q != CNT_MAX);
    assign accept   = in_valid & in_ready;
    assign enq      = accept & ~fault;
    assign deq      = mem_valid & mem_ready;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        exc_valid_d = accept & fault;
        exc_cause_d = exc_cause_q;
        exc_addr_d  = exc_addr_q;
        if (enq) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (deq) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({enq, deq})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (accept && fault) begin
            exc_cause_d = cause;
            exc_addr_d  = fault_addr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= EXC_NONE;
            exc_addr_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            exc_addr_q  <= exc_addr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) fifo_q[wr_ptr_q] <= new_entry;
    end

    assign head = fifo_q[rd_ptr_q];

    // Storage is not reset; gating with mem_valid keeps the port at zero when idle.
    assign mem_valid = (count_q != '0);
    assign mem_addr  = mem_valid ? head.addr[XLEN-1:0]    : '0;
    assign mem_wdata = mem_valid ? head.wdata[XLEN-1:0]   : '0;
    assign mem_wstrb = mem_valid ? head.wstrb[XLEN/8-1:0] : '0;
    assign mem_size  = mem_valid ? head.size              : SZ_NONE;

    assign exc_valid = exc_valid_q;
    assign exc_cause = exc_cause_q;
    assign exc_addr  = exc_addr_q;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_MAX);

    generate
        if (XLEN < XLEN_MAX) begin : g_narrow
            logic unused_hi;
            assign unused_hi = ^{head.addr[XLEN_MAX-1:XLEN],
                                 head.wdata[XLEN_MAX-1:XLEN],
                                 head.wstrb[XLEN_MAX/8-1:XLEN/8]};
        end
    endgenerate

endmodule

// File: tb/tb_store_queue.sv
// Self-checking bench for store_queue (XLEN=32, DEPTH=4) against a queue-based
// reference model of the store rules.
module tb_store_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  size;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1_data;
    logic [31:0] src2_data;
    logic [2:0]  funct3;
    logic [11:0] imm12;
    logic        exc_valid;
    logic [1:0]  exc_cause;
    logic [31:0] exc_addr;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [2:0]  mem_size;
    logic [2:0]  count;
    logic        empty;
    logic        full;

    int n_tests = 0;
    int n_fail  = 0;

    ent_t        exp_q[$];
    logic        m_exc_valid;
    logic [1:0]  m_exc_cause;
    logic [31:0] m_exc_addr;

    store_queue #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1_data (src1_data),
        .src2_data (src2_data),
        .funct3    (funct3),
        .imm12     (imm12),
        .exc_valid (exc_valid),
        .exc_cause (exc_cause),
        .exc_addr  (exc_addr),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_size  (mem_size),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    always #5 clk = ~clk;

    // Reference: access of 2^f3 bytes, must be naturally aligned, data placed at addr%4.
    function automatic void model(input logic [31:0] s1, input logic [31:0] s2,
                                  input logic [2:0] f3, input logic [11:0] imm,
                                  output ent_t e, output logic [1:0] cause);
        int unsigned nb;
        int unsigned lane;
        longint unsigned m;
        e.addr  = s1 + 32'($signed(imm));
        e.wdata = '0;
        e.strb  = '0;
        e.size  = '0;
        cause   = 2'b00;
        if (f3 > 3'd2) begin
            cause = 2'b10;
            return;
        end
        nb = 1 << f3;
        if ((e.addr % nb) != 0) begin
            cause = 2'b01;
            return;
        end
        lane   = e.addr % 4;
        e.size = f3 + 3'd1;
        e.strb = 4'(((1 << nb) - 1) << lane);
        m      = (64'(s2) & ((64'd1 << (8*nb)) - 64'd1)) << (8*lane);
        e.wdata = m[31:0];
    endfunction

    // Drive one cycle of inputs at a negedge, advance the model past the next
    // posedge, and return at the following negedge.
    task automatic step(input logic v, input logic [31:0] s1, input logic [31:0] s2,
                        input logic [2:0] f3, input logic [11:0] imm, input logic mr);
        ent_t       e;
        logic [1:0] c;
        bit         acc;
        bit         deq;
        in_valid  = v;
        src1_data = s1;
        src2_data = s2;
        funct3    = f3;
        imm12     = imm;
        mem_ready = mr;
        acc = v && (exp_q.size() < DEPTH);
        deq = (exp_q.size() != 0) && mr;
        model(s1, s2, f3, imm, e, c);
        if (deq) void'(exp_q.pop_front());
        m_exc_valid = 1'b0;
        if (acc) begin
            if (c != 2'b00) begin
                m_exc_valid = 1'b1;
                m_exc_cause = c;
                m_exc_addr  = e.addr;
            end else begin
                exp_q.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic mr);
        step(1'b0, 32'h0, 32'h0, 3'b000, 12'h000, mr);
    endtask

    task automatic test_reset;
        logic [6:0] obs;
        n_tests++;
        obs = {count, empty, full, in_ready, mem_valid};
        if (obs !== 7'b000_1_0_1_0) begin
            n_fail++;
            $display("FAIL reset_status: got %b expected %b", obs, 7'b000_1_0_1_0);
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_wstrb, mem_size} !== 71'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb, mem_size});
        end
        n_tests++;
        if ({exc_valid, exc_cause, exc_addr} !== 35'h0) begin
            n_fail++;
            $display("FAIL reset_exc: got %h expected 0", {exc_valid, exc_cause, exc_addr});
        end
    endtask

    task automatic test_sw;
        logic [71:0] obs;
        logic [71:0] exp;
        step(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 3'b010, 12'hFFC, 1'b1);
        obs = {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size};
        exp = {1'b1, 32'h0000_0FFC, 32'hDEAD_BEEF, 4'hF, 3'b011};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL sw_neg_imm: got %h expected %h", obs, exp);
        end
        idle(1'b1);
        n_tests++;
        if ({empty, count} !== 4'b1_000) begin
            n_fail++;
            $display("FAIL sw_dequeued: got empty=%b count=%0d expected empty=1 count=0", empty, count);
        end
    endtask

    task automatic test_sb_sh;
        logic [71:0] obs;
        logic [71:0] exp;
        step(1'b1, 32'h0000_2003, 32'h0000_00A5, 3'b000, 12'h000, 1'b1);
        obs = {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size};
        exp = {1'b1, 32'h0000_2003, 32'hA500_0000, 4'h8, 3'b001};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL sb_lane3: got %h expected %h", obs, exp);
        end
        // Address wraps modulo 2^32 to 0x2, a legal upper-half store.
        step(1'b1, 32'hFFFF_FFFE, 32'h1234_ABCD, 3'b001, 12'h004, 1'b1);
        obs = {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size};
        exp = {1'b1, 32'h0000_0002, 32'hABCD_0000, 4'hC, 3'b010};
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL sh_addr_wrap: got %h expected %h", obs, exp);
        end
        idle(1'b1);
    endtask

    task automatic test_faults;
        logic [34:0] obs;
        step(1'b1, 32'h0000_3001, 32'h1111_2222, 3'b001, 12'h000, 1'b1);
        obs = {exc_valid, exc_cause, exc_addr};
        n_tests++;
        if (obs !== {1'b1, 2'b01, 32'h0000_3001} || count !== 3'd0) begin
            n_fail++;
            $display("FAIL sh_misaligned: got exc=%h count=%0d expected %h count=0",
                     obs, count, {1'b1, 2'b01, 32'h0000_3001});
        end
        idle(1'b1);
        obs = {exc_valid, exc_cause, exc_addr};
        n_tests++;
        if (obs !== {1'b0, 2'b01, 32'h0000_3001}) begin
            n_fail++;
            $display("FAIL exc_pulse_hold: got %h expected %h", obs, {1'b0, 2'b01, 32'h0000_3001});
        end
        // funct3=011 on a 32-bit build is illegal, and wins over misalignment.
        step(1'b1, 32'h0000_4001, 32'h0, 3'b011, 12'h000, 1'b1);
        obs = {exc_valid, exc_cause, exc_addr};
        n_tests++;
        if (obs !== {1'b1, 2'b10, 32'h0000_4001} || mem_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sd_illegal: got exc=%h mem_valid=%b expected %h mem_valid=0",
                     obs, mem_valid, {1'b1, 2'b10, 32'h0000_4001});
        end
        idle(1'b1);
        n_tests++;
        if (exc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_clear: got %b expected 0", exc_valid);
        end
    endtask

    task automatic test_full_drain;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h0000_0100 + 32'(4*i), 32'h1111_1111 * 32'(i+1), 3'b010, 12'h000, 1'b0);
        end
        n_tests++;
        if ({count, full, in_ready} !== {3'd4, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL fill_full: got count=%0d full=%b in_ready=%b expected 4 1 0", count, full, in_ready);
        end
        // Fifth store while full with a dequeue in the same cycle: must not be taken.
        step(1'b1, 32'h0000_0200, 32'hFFFF_FFFF, 3'b010, 12'h000, 1'b1);
        n_tests++;
        if ({count, mem_addr} !== {3'd3, 32'h0000_0104}) begin
            n_fail++;
            $display("FAIL no_bypass: got count=%0d head=%h expected 3 00000104", count, mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({count, mem_addr, mem_wdata} !== {3'(3-i), 32'h0000_0104 + 32'(4*i), 32'h1111_1111 * 32'(i+2)}) begin
                n_fail++;
                $display("FAIL drain_order_%0d: got count=%0d addr=%h data=%h expected %0d %h %h", i,
                         count, mem_addr, mem_wdata, 3-i, 32'h0000_0104 + 32'(4*i), 32'h1111_1111 * 32'(i+2));
            end
            idle(1'b1);
        end
        n_tests++;
        if ({empty, count} !== 4'b1_000) begin
            n_fail++;
            $display("FAIL drain_empty: got empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 32'h0000_0A00, 32'hA0, 3'b000, 12'h000, 1'b0);
        step(1'b1, 32'h0000_0A01, 32'hA1, 3'b000, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_0A02 + 32'(i), 32'(8'hA2 + i), 3'b000, 12'h000, 1'b1);
            n_tests++;
            if ({count, mem_addr} !== {3'd2, 32'h0000_0A01 + 32'(i)}) begin
                n_fail++;
                $display("FAIL simul_enq_deq_%0d: got count=%0d head=%h expected 2 %h", i,
                         count, mem_addr, 32'h0000_0A01 + 32'(i));
            end
        end
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (mem_addr !== 32'h0000_0A03 + 32'(i)) begin
                n_fail++;
                $display("FAIL wrap_order_%0d: got %h expected %h", i, mem_addr, 32'h0000_0A03 + 32'(i));
            end
            idle(1'b1);
        end
    endtask

    task automatic test_random;
        logic [5:0]  obs_s;
        logic [5:0]  exp_s;
        logic [71:0] obs_m;
        logic [71:0] exp_m;
        logic [34:0] exp_e;
        logic        aligned;
        logic [31:0] s1;
        logic [11:0] imm;
        logic [2:0]  f3;
        for (int n = 0; n < 300; n++) begin
            exp_s = {3'(exp_q.size()), exp_q.size() == 0, exp_q.size() == DEPTH, exp_q.size() != DEPTH};
            obs_s = {count, empty, full, in_ready};
            n_tests++;
            if (obs_s !== exp_s) begin
                n_fail++;
                $display("FAIL rand_status@%0d: got %b expected %b", n, obs_s, exp_s);
            end
            obs_m = {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size};
            exp_m = (exp_q.size() != 0) ?
                    {1'b1, exp_q[0].addr, exp_q[0].wdata, exp_q[0].strb, exp_q[0].size} : '0;
            n_tests++;
            if (obs_m !== exp_m) begin
                n_fail++;
                $display("FAIL rand_head@%0d: got %h expected %h", n, obs_m, exp_m);
            end
            exp_e = {m_exc_valid, m_exc_cause, m_exc_addr};
            n_tests++;
            if ({exc_valid, exc_cause, exc_addr} !== exp_e) begin
                n_fail++;
                $display("FAIL rand_exc@%0d: got %h expected %h", n, {exc_valid, exc_cause, exc_addr}, exp_e);
            end
            aligned = ($urandom_range(0, 1) == 1);
            s1  = aligned ? ($urandom & 32'hFFFF_FFF0) : $urandom;
            imm = aligned ? (12'($urandom) & 12'hFF0) : 12'($urandom);
            f3  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            step($urandom_range(0, 3) != 0, s1, $urandom, f3, imm, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);
        n_tests++;
        if (empty !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_final_empty: got %b expected 1", empty);
        end
    endtask

    task automatic test_reset_mid_drain;
        logic [71:0] obs_m;
        step(1'b1, 32'h0000_5001, 32'h0, 3'b010, 12'h000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h0000_0500 + 32'(4*i), 32'h5555_0000 + 32'(i), 3'b010, 12'h000, 1'b0);
        end
        in_valid  = 1'b0;
        mem_ready = 1'b1;
        n_tests++;
        if (count !== 3'd3 || exc_cause !== 2'b01) begin
            n_fail++;
            $display("FAIL pre_reset: got count=%0d cause=%b expected 3 01", count, exc_cause);
        end
        #1;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({count, empty, full, mem_valid, exc_valid, exc_cause, exc_addr} !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 32'h0}) begin
            n_fail++;
            $display("FAIL async_reset_status: got count=%0d empty=%b full=%b mem_valid=%b exc=%h expected 0 1 0 0 0",
                     count, empty, full, mem_valid, {exc_valid, exc_cause, exc_addr});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_wstrb, mem_size} !== 71'h0) begin
            n_fail++;
            $display("FAIL async_reset_mem: got %h expected 0", {mem_addr, mem_wdata, mem_wstrb, mem_size});
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        m_exc_valid = 1'b0;
        m_exc_cause = 2'b00;
        m_exc_addr  = 32'h0;
        step(1'b1, 32'h0000_0600, 32'h0000_0077, 3'b000, 12'h000, 1'b1);
        n_tests++;
        if ({mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size} !== {1'b1, 32'h600, 32'h77, 4'h1, 3'b001}) begin
            obs_m = {mem_valid, mem_addr, mem_wdata, mem_wstrb, mem_size};
            n_fail++;
            $display("FAIL post_reset_store: got %h expected %h", obs_m, {1'b1, 32'h600, 32'h77, 4'h1, 3'b001});
        end
        idle(1'b1);
        n_tests++;
        if ({empty, count} !== 4'b1_000) begin
            n_fail++;
            $display("FAIL post_reset_drain: got empty=%b count=%0d expected 1 0", empty, count);
        end
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        src1_data   = '0;
        src2_data   = '0;
        funct3      = '0;
        imm12       = '0;
        mem_ready   = 1'b0;
        m_exc_valid = 1'b0;
        m_exc_cause = 2'b00;
        m_exc_addr  = 32'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        test_reset;
        test_sw;
        test_sb_sh;
        test_faults;
        test_full_drain;
        test_back_to_back;
        test_random;
        test_reset_mid_drain;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/store_queue.md
Name: store_queue

Overview:
- Parametrised successor to the single-cycle store decoder: a buffered store unit between execute and the data-memory port.
- Accepts RISC-V store ops (SB/SH/SW, plus SD when XLEN=64) over a valid/ready handshake.
- Computes effective address, byte strobes and lane-aligned write data; checks alignment and funct3 legality.
- Queues legal stores in a DEPTH-entry FIFO and drains them in order to memory over a second valid/ready handshake.

Parameters:
XLEN, 32, datapath/address width; legal values 32 or 64
DEPTH, 4, store buffer entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  store request valid
in_ready  out  1  store request accepted when in_valid && in_ready
src1_data  in  XLEN  base register value
src2_data  in  XLEN  store data register value
funct3  in  3  store width selector
imm12  in  12  signed S-type offset
exc_valid  out  1  one-cycle fault pulse
exc_cause  out  2  01 misaligned, 10 illegal funct3, 00 none
exc_addr  out  XLEN  faulting effective address
mem_valid  out  1  head entry presented to memory
mem_ready  in  1  memory accepts head
mem_addr  out  XLEN  effective address, low bits unmasked
mem_wdata  out  XLEN  lane-shifted write data
mem_wstrb  out  XLEN/8  byte-enable strobes
mem_size  out  3  001 byte, 010 half, 011 word, 100 double (000 never driven while valid)
count  out  CNT_W  entries held
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Reset: pointers, count, exc_valid, exc_cause, exc_addr, and all mem_* outputs go to 0; empty=1, full=0. Reset mid-drain discards all entries. No memory handshake completes in the reset cycle.
- in_ready = !full. No full-bypass: a dequeue in the same cycle does not open a slot for a request arriving that cycle.
- Effective address = src1_data + sign-extend(imm12) to XLEN, modulo 2^XLEN (wraps).
- funct3 000/001/010 map to byte/half/word. funct3 011 maps to double only if XLEN=64. All other funct3 values are illegal.
- Lane offset = addr[1:0] (XLEN=32) or addr[2:0] (XLEN=64).
- Misaligned: half with addr[0]=1; word with addr[1:0]!=0; double with addr[2:0]!=0.
- Byte strobes:
  - wstrb = size mask << offset (mask 1, 3, F or FF).
  - wdata = src2 low bytes replicated/shifted into the selected lanes; unselected lanes are 0.
- Accept with a legal, aligned store: entry written at the tail. Visible on mem_valid the next cycle at the earliest.
- Accept with a fault:
  - Nothing enqueued.
  - Next cycle: exc_valid=1 for exactly one cycle, with cause and address.
  - Illegal funct3 takes priority over misalignment.
  - Without a new fault, exc_valid returns to 0; exc_cause and exc_addr hold their last values.
- mem_valid = !empty. The head is stable while mem_valid && !mem_ready. Dequeue on mem_valid && mem_ready.
- Simultaneous enqueue and dequeue (not full): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Order is strictly FIFO.
- Latency: 1 cycle from accept to mem_valid when the queue was empty. Throughput: 1 store per cycle sustained while mem_ready=1.

Decomposition:
- Shared package store_pkg holds:
  - funct3 constants (SB/SH/SW/SD)
  - size encodings (SZ_NONE, SZ_B, SZ_H, SZ_W, SZ_D)
  - cause codes (EXC_NONE, EXC_MISALIGN, EXC_ILLEGAL)
  - packed store_entry_t {addr, wdata, wstrb, size}
- One combinational sub-module, store_align: computes address, size, strobes, data and fault.
- The FIFO and the exception register live in store_queue.

Test Plan:
- XLEN=32, src1=0x1000, imm12=0xFFC (-4), funct3=010, src2=0xDEADBEEF, mem_ready=1 -> next cycle mem_valid=1, addr=0x0FFC, wdata=0xDEADBEEF, wstrb=F, size=011; dequeued that cycle.
- SB with src1=0x2003, imm12=0, src2=0x000000A5 -> addr=0x2003, wdata=0xA5000000, wstrb=8, size=001.
- SH with addr=0x3001 -> no enqueue; next cycle exc_valid=1 for one cycle, cause=01, exc_addr=0x3001. funct3=011 on XLEN=32 -> cause=10.
- mem_ready=0, issue 4 legal stores back-to-back -> count=4, full=1, in_ready=0, 5th held. Raise mem_ready -> drained in issue order, one per cycle, count down to 0.
- Count=2 with simultaneous enqueue and dequeue for 3 cycles -> count stays 2; pointer wrap preserves order.
- Assert rst mid-drain with 3 entries -> all outputs 0, empty=1 immediately (asynchronous). After release, a new store drains normally.
